dma_cmd_sequencer: RTL and testbench
====================================

// Module: dma_cmd_sequencer
// PURPOSE
//  Sequences the MM2S AXI datamover on AXI_HP0 for SHA-256 input fetch. Splits one job (base addr,
//  bit length) into datamover commands of at most CHUNK_BYTES each and throttles issue on FIFO fill,
//  sha256 readiness and outstanding-command count. Checks every returned status word in order and
//  reports done/error to the register block. Sits between the register block and dma_engine's datamover.
// PARAMETERS
//  CHUNK_BYTES     64      max BTT per command (one 512-bit SHA-256 block); power of 2, <=2^22
//  MAX_OUTST       2       max commands issued without a returned status (1..15)
//  FIFO_HIGH_WATER 9'h1E0  issue only if fifo_wr_count_i <= this value
//  TIMEOUT_CYC     2**20   watchdog limit in cycles; used only with DMA_SEQ_TIMEOUT_EN
// PORTS
//  clk_i            in   1   clock, all logic rising edge
//  rst_i            in   1   synchronous reset, active-high
//  dma_enable_i     in   1   job enable; low aborts/clears
//  dma_start_i      in   1   start request, sampled in IDLE only
//  dma_base_addr_i  in   32  byte start address, bits [2:0] ignored (forced 0)
//  dma_bit_len_i    in   32  job length in bits
//  sha256_rdy_i     in   1   hasher ready to accept a job
//  fifo_wr_count_i  in   9   FIFO fill level, 32-bit words
//  cmd_tdata_o      out  72  datamover MM2S command
//  cmd_tvalid_o     out  1   AXIS valid
//  cmd_tready_i     in   1   AXIS ready
//  sts_tdata_i      in   8   datamover status {OKAY,SLVERR,DECERR,INTERR,TAG[3:0]}
//  sts_tvalid_i     in   1   AXIS valid
//  sts_tready_o     out  1   AXIS ready
//  busy_o           out  1   job in progress
//  done_o           out  1   one-cycle pulse, job completed OK
//  err_o            out  1   sticky error flag
//  err_code_o       out  3   0 none,1 SLVERR,2 DECERR,3 INTERR,4 TAG,5 ABORT,6 TIMEOUT
//  dbg_state_o      out  4   current state encoding
// BEHAVIOUR
//  Reset: all outputs 0 (sts_tready_o 0), state IDLE, counters 0.
//  sts_tready_o=1 in every state except reset; statuses are consumed every cycle.
//  Command: [22:0] BTT, [23] TYPE=1 (INCR), [29:24] DSA=0, [30] EOF (1 on last chunk), [31] DRR=0,
//   [63:32] SADDR, [67:64] TAG, [71:68] 0.
//  IDLE: start && enable && sha256_rdy && |bit_len -> latch addr=base&~7, bytes_left=(bit_len+7)>>3
//   (33-bit add, no overflow), tag=0, err cleared, busy_o=1 -> CHECK. Otherwise stay; start ignored.
//  CHECK: !enable -> DRAIN with abort flag; bytes_left==0 -> DRAIN; else if outst<MAX_OUTST &&
//   fifo_wr_count_i<=FIFO_HIGH_WATER && sha256_rdy_i -> drive cmd, tvalid=1 -> ISSUE; else stay.
//  ISSUE: tdata stable and tvalid held until tready, even if enable drops. On handshake: addr+=BTT,
//   bytes_left-=BTT, outst++, tag++ (mod 16) -> CHECK. Command latency: CHECK->tvalid is 1 cycle.
//  BTT = min(bytes_left, CHUNK_BYTES); final chunk may be short; EOF set when BTT==bytes_left.
//  Status check (any state): tag!=expected or outst==0 -> err 4; INTERR/DECERR/SLVERR -> err 3/2/1
//   (priority INTERR>DECERR>SLVERR>TAG); OKAY with match -> outst--, expected++. Status and command
//   handshake in the same cycle: outst unchanged.
//  First error latches err_code_o (later errors do not overwrite), err_o=1, -> ERROR.
//  DRAIN: wait outst==0 -> abort ? ERROR(code 5) : DONE.
//  DONE: done_o=1 for one cycle, busy_o=0 -> IDLE.
//  ERROR: busy_o=0, no commands issued; statuses still drained; leave to IDLE when enable==0.
//  ERROR->IDLE keeps err_o until the next accepted start clears it.
//  rst_i mid-job: immediate IDLE; tvalid dropped (datamover is reset by the same source).
// CONFIGURATION
//  DMA_SEQ_TIMEOUT_EN defined: cycle counter cleared on any cmd/sts handshake, counts while busy_o;
//   reaching TIMEOUT_CYC -> err 6, ERROR state. Undefined: no watchdog; code 6 never produced.
// STRUCTURE
//  Package dma_pkg: state enum (IDLE,CHECK,ISSUE,DRAIN,DONE,ERROR), err_code enum,
//   cmd field offsets/width constants, status bit positions.
//  Sub-module dma_sts_checker: status decode, expected-tag and outstanding counter, error priority.
// TESTING
//  bit_len=512, base=0x1000_0000 -> one cmd BTT=64 EOF=1 TAG=0; OKAY sts tag0 -> done_o 1 cycle.
//  bit_len=1224 -> cmds BTT 64,64,25 at +0,+64,+128, tags 0..2, EOF only on last; done after 3 sts.
//  fifo_wr_count_i=0x1E1 for 50 cycles then 0x1E0 -> no tvalid until drop, then issue next cycle.
//  cmd_tready_i=0 for 10 cycles -> tdata/tvalid stable; MAX_OUTST=2 with statuses withheld -> 3rd cmd waits.
//  status tag 1 while expecting 0 -> err_o=1, code 4, no further cmds; enable=0 -> IDLE.
//  enable low during CHECK with 2 outstanding -> DRAIN, after 2 OKAY sts -> code 5; timeout (macro on)
//   with TIMEOUT_CYC=100 and no sts -> code 6 at cycle 100.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared state/error encodings and datamover command/status field layout
// for the SHA-256 input-fetch DMA command sequencer.
package dma_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CHECK = 4'd1,
        ST_ISSUE = 4'd2,
        ST_DRAIN = 4'd3,
        ST_DONE  = 4'd4,
        ST_ERROR = 4'd5
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_SLVERR  = 3'd1,
        ERR_DECERR  = 3'd2,
        ERR_INTERR  = 3'd3,
        ERR_TAG     = 3'd4,
        ERR_ABORT   = 3'd5,
        ERR_TIMEOUT = 3'd6
    } err_code_t;

    localparam int CMD_W         = 72;
    localparam int CMD_BTT_W     = 23;
    localparam int CMD_TYPE_BIT  = 23;
    localparam int CMD_DSA_LSB   = 24;
    localparam int CMD_EOF_BIT   = 30;
    localparam int CMD_DRR_BIT   = 31;
    localparam int CMD_SADDR_LSB = 32;
    localparam int CMD_TAG_LSB   = 64;

    localparam int STS_OKAY_BIT   = 7;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_INTERR_BIT = 4;

    // Fixed-type INCR command with no DRE realignment; only BTT/EOF/SADDR/TAG vary.
    function automatic logic [CMD_W-1:0] build_cmd(
        input logic [CMD_BTT_W-1:0] btt,
        input logic                 eof,
        input logic [31:0]          saddr,
        input logic [3:0]           tag
    );
        logic [CMD_W-1:0] cmd;
        cmd                       = '0;
        cmd[CMD_BTT_W-1:0]        = btt;
        cmd[CMD_TYPE_BIT]         = 1'b1;
        cmd[CMD_DSA_LSB +: 6]     = 6'd0;
        cmd[CMD_EOF_BIT]          = eof;
        cmd[CMD_DRR_BIT]          = 1'b0;
        cmd[CMD_SADDR_LSB +: 32]  = saddr;
        cmd[CMD_TAG_LSB +: 4]     = tag;
        return cmd;
    endfunction

endpackage

// File: rtl/dma_sts_checker.sv
// Datamover status decoder: tracks the expected in-order tag and the
// outstanding-command count, and classifies each status by error priority.
module dma_sts_checker
    import dma_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       sts_fire_i,
    input  logic [7:0] sts_tdata_i,
    input  logic       cmd_fire_i,
    output logic [3:0] outst_o,
    output logic       err_valid_o,
    output err_code_t  err_code_o
);

    logic [3:0] exp_tag_q;
    logic [3:0] outst_q;
    logic       tag_bad;
    logic       sts_good;
    err_code_t  code;

    // Bus error flags outrank a tag mismatch; a status with nothing outstanding is a tag error.
    always_comb begin
        tag_bad = (sts_tdata_i[3:0] != exp_tag_q) || (outst_q == 4'd0);
        code    = ERR_NONE;
        if (sts_tdata_i[STS_INTERR_BIT]) begin
            code = ERR_INTERR;
        end else if (sts_tdata_i[STS_DECERR_BIT]) begin
            code = ERR_DECERR;
        end else if (sts_tdata_i[STS_SLVERR_BIT]) begin
            code = ERR_SLVERR;
        end else if (tag_bad) begin
            code = ERR_TAG;
        end
        err_valid_o = sts_fire_i && (code != ERR_NONE);
        err_code_o  = code;
        sts_good    = sts_fire_i && (code == ERR_NONE) && sts_tdata_i[STS_OKAY_BIT];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            exp_tag_q <= 4'd0;
            outst_q   <= 4'd0;
        end else begin
            if (sts_good) begin
                exp_tag_q <= exp_tag_q + 4'd1;
            end
            if (cmd_fire_i && !sts_good) begin
                outst_q <= outst_q + 4'd1;
            end else if (sts_good && !cmd_fire_i) begin
                outst_q <= outst_q - 4'd1;
            end
        end
    end

    assign outst_o = outst_q;

endmodule

// File: rtl/dma_cmd_sequencer.sv
// Splits a SHA-256 fetch job into MM2S datamover commands and checks returned statuses.
// Optional watchdog enabled by defining DMA_SEQ_TIMEOUT_EN.
module dma_cmd_sequencer
    import dma_pkg::*;
#(
    parameter int unsigned CHUNK_BYTES     = 64,
    parameter int unsigned MAX_OUTST       = 2,
    parameter logic [8:0]  FIFO_HIGH_WATER = 9'h1E0,
    parameter int unsigned TIMEOUT_CYC     = 2**20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dma_enable_i,
    input  logic        dma_start_i,
    input  logic [31:0] dma_base_addr_i,
    input  logic [31:0] dma_bit_len_i,
    input  logic        sha256_rdy_i,
    input  logic [8:0]  fifo_wr_count_i,
    output logic [71:0] cmd_tdata_o,
    output logic        cmd_tvalid_o,
    input  logic        cmd_tready_i,
    input  logic [7:0]  sts_tdata_i,
    input  logic        sts_tvalid_i,
    output logic        sts_tready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  err_code_o,
    output logic [3:0]  dbg_state_o
);

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [32:0]        bytes_left_q, bytes_left_d;
    logic [3:0]         tag_q, tag_d;
    logic               abort_q, abort_d;
    logic               err_q, err_d;
    err_code_t          code_q, code_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic               sts_ready_q;

    logic               cmd_fire;
    logic               sts_fire;
    logic               job_accept;
    logic               eof_c;
    logic [CMD_BTT_W-1:0] btt_c;
    logic [3:0]         outst;
    logic               chk_err_valid;
    err_code_t          chk_err_code;
    logic               wd_expired;
    logic               err_event;
    err_code_t          err_event_code;

    assign cmd_fire = (state_q == ST_ISSUE) && cmd_tready_i;
    assign sts_fire = sts_tvalid_i && sts_ready_q;
    assign eof_c    = (bytes_left_q <= 33'(CHUNK_BYTES));
    assign btt_c    = eof_c ? bytes_left_q[CMD_BTT_W-1:0] : CMD_BTT_W'(CHUNK_BYTES);

    dma_sts_checker u_sts_checker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (job_accept),
        .sts_fire_i  (sts_fire),
        .sts_tdata_i (sts_tdata_i),
        .cmd_fire_i  (cmd_fire),
        .outst_o     (outst),
        .err_valid_o (chk_err_valid),
        .err_code_o  (chk_err_code)
    );

`ifdef DMA_SEQ_TIMEOUT_EN
    // Any handshake proves the datamover is alive, so it restarts the count.
    logic [31:0] wd_cnt_q;
    assign wd_expired = busy_o && !cmd_fire && !sts_fire && (wd_cnt_q == 32'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk_i) begin
        if (rst_i || !busy_o || cmd_fire || sts_fire) begin
            wd_cnt_q <= 32'd0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 32'd1;
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYC == 0);
    assign wd_expired     = 1'b0;
`endif

    assign err_event      = chk_err_valid || wd_expired;
    assign err_event_code = chk_err_valid ? chk_err_code : ERR_TIMEOUT;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        bytes_left_d = bytes_left_q;
        tag_d        = tag_q;
        abort_d      = abort_q;
        err_d        = err_q;
        code_d       = code_q;
        cmd_d        = cmd_q;
        job_accept   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dma_start_i && dma_enable_i && sha256_rdy_i && (|dma_bit_len_i)) begin
                    job_accept   = 1'b1;
                    addr_d       = {dma_base_addr_i[31:3], 3'b000};
                    bytes_left_d = ({1'b0, dma_bit_len_i} + 33'd7) >> 3;
                    tag_d        = 4'd0;
                    abort_d      = 1'b0;
                    err_d        = 1'b0;
                    code_d       = ERR_NONE;
                    state_d      = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!dma_enable_i) begin
                    abort_d = 1'b1;
                    state_d = ST_DRAIN;
                end else if (bytes_left_q == 33'd0) begin
                    state_d = ST_DRAIN;
                end else if ((32'(outst) < MAX_OUTST) && (fifo_wr_count_i <= FIFO_HIGH_WATER)
                             && sha256_rdy_i) begin
                    cmd_d   = build_cmd(btt_c, eof_c, addr_q, tag_q);
                    state_d = ST_ISSUE;
                end
            end
            // The command stays on the bus until accepted, even through an enable drop.
            ST_ISSUE: begin
                if (cmd_tready_i) begin
                    addr_d       = addr_q + 32'(cmd_q[CMD_BTT_W-1:0]);
                    bytes_left_d = bytes_left_q - 33'(cmd_q[CMD_BTT_W-1:0]);
                    tag_d        = tag_q + 4'd1;
                    state_d      = ST_CHECK;
                end
            end
            ST_DRAIN: begin
                if (outst == 4'd0) begin
                    if (abort_q) begin
                        state_d = ST_ERROR;
                        if (!err_q) begin
                            err_d  = 1'b1;
                            code_d = ERR_ABORT;
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (!dma_enable_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Only the first error of a job is recorded.
        if (err_event) begin
            state_d = ST_ERROR;
            if (!err_d) begin
                err_d  = 1'b1;
                code_d = err_event_code;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= 32'd0;
            bytes_left_q <= 33'd0;
            tag_q        <= 4'd0;
            abort_q      <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= ERR_NONE;
            cmd_q        <= '0;
            sts_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            bytes_left_q <= bytes_left_d;
            tag_q        <= tag_d;
            abort_q      <= abort_d;
            err_q        <= err_d;
            code_q       <= code_d;
            cmd_q        <= cmd_d;
            sts_ready_q  <= 1'b1;
        end
    end

    assign cmd_tdata_o  = cmd_q;
    assign cmd_tvalid_o = (state_q == ST_ISSUE);
    assign sts_tready_o = sts_ready_q;
    assign busy_o       = (state_q == ST_CHECK) || (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = err_q;
    assign err_code_o   = code_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Directed bench for dma_cmd_sequencer: expected commands are queued per job and
// compared on each handshake; status replies are injected by hand.
module tb_dma_cmd_sequencer;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CHECK = 4'd1;
    localparam logic [3:0] S_DRAIN = 4'd3;
    localparam logic [3:0] S_ERROR = 4'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_enable;
    logic        dma_start;
    logic [31:0] dma_base_addr;
    logic [31:0] dma_bit_len;
    logic        sha256_rdy;
    logic [8:0]  fifo_wr_count;
    logic [71:0] cmd_tdata_o;
    logic        cmd_tvalid_o;
    logic        cmd_tready;
    logic [7:0]  sts_tdata;
    logic        sts_tvalid;
    logic        sts_tready_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [2:0]  err_code_o;
    logic [3:0]  dbg_state_o;

    logic [71:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dma_cmd_sequencer #(
        .CHUNK_BYTES     (64),
        .MAX_OUTST       (2),
        .FIFO_HIGH_WATER (9'h1E0),
        .TIMEOUT_CYC     (100)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .dma_enable_i    (dma_enable),
        .dma_start_i     (dma_start),
        .dma_base_addr_i (dma_base_addr),
        .dma_bit_len_i   (dma_bit_len),
        .sha256_rdy_i    (sha256_rdy),
        .fifo_wr_count_i (fifo_wr_count),
        .cmd_tdata_o     (cmd_tdata_o),
        .cmd_tvalid_o    (cmd_tvalid_o),
        .cmd_tready_i    (cmd_tready),
        .sts_tdata_i     (sts_tdata),
        .sts_tvalid_i    (sts_tvalid),
        .sts_tready_o    (sts_tready_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .err_code_o      (err_code_o),
        .dbg_state_o     (dbg_state_o)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [71:0] mk_cmd(input int unsigned btt, input logic eof,
                                           input logic [31:0] addr, input logic [3:0] tag);
        logic [22:0] b;
        b = btt[22:0];
        return {4'h0, tag, addr, 1'b0, eof, 6'h00, 1'b1, b};
    endfunction

    // Reference chunking of a job into the command sequence the datamover should see.
    task automatic push_job(input logic [31:0] base, input logic [31:0] bit_len);
        logic [63:0] bytes;
        logic [31:0] addr;
        logic [3:0]  tag;
        int unsigned btt;
        bytes = ({32'd0, bit_len} + 64'd7) >> 3;
        addr  = base & 32'hFFFF_FFF8;
        tag   = 4'd0;
        while (bytes > 0) begin
            btt = (bytes > 64) ? 64 : int'(bytes);
            exp_q.push_back(mk_cmd(btt, (bytes <= 64), addr, tag));
            addr  = addr + btt;
            bytes = bytes - btt;
            tag   = tag + 4'd1;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] bit_len);
        dma_base_addr = base;
        dma_bit_len   = bit_len;
        dma_start     = 1'b1;
        tick();
        dma_start     = 1'b0;
    endtask

    task automatic accept_cmd(input string tag, input int hold);
        int          waited;
        logic [71:0] held;
        logic [71:0] exp;
        waited = 0;
        while (!cmd_tvalid_o && waited < 200) begin
            tick();
            waited++;
        end
        if (!cmd_tvalid_o) begin
            checkOutput({tag, "_tvalid_wait"}, 72'(cmd_tvalid_o), 72'd1);
            return;
        end
        held = cmd_tdata_o;
        if (hold > 0) begin
            tick(hold);
            checkOutput({tag, "_hold_tvalid"}, 72'(cmd_tvalid_o), 72'd1);
            checkOutput({tag, "_hold_tdata"}, cmd_tdata_o, held);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        cmd_tready = 1'b1;
        checkOutput(tag, cmd_tdata_o, exp);
        tick();
        cmd_tready = 1'b0;
    endtask

    task automatic send_sts(input logic [7:0] data);
        sts_tdata  = data;
        sts_tvalid = 1'b1;
        tick();
        sts_tvalid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int waited;
        waited = 0;
        while (!done_o && waited < 200) begin
            tick();
            waited++;
        end
        checkOutput({tag, "_done"}, 72'(done_o), 72'd1);
        tick();
        checkOutput({tag, "_done_pulse"}, 72'(done_o), 72'd0);
        checkOutput({tag, "_idle"}, 72'(dbg_state_o), 72'(S_IDLE));
        checkOutput({tag, "_no_err"}, 72'(err_o), 72'd0);
    endtask

    task automatic wait_err(input string tag, input logic [2:0] code);
        int waited;
        waited = 0;
        while (!err_o && waited < 200) begin
            tick();
            waited++;
        end
        checkOutput({tag, "_err"}, 72'(err_o), 72'd1);
        checkOutput({tag, "_code"}, 72'(err_code_o), 72'(code));
        checkOutput({tag, "_state"}, 72'(dbg_state_o), 72'(S_ERROR));
        checkOutput({tag, "_busy"}, 72'(busy_o), 72'd0);
    endtask

    task automatic expect_no_issue(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (cmd_tvalid_o) seen = 1'b1;
        end
        checkOutput(tag, 72'(seen), 72'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        rst           = 1'b1;
        dma_enable    = 1'b0;
        dma_start     = 1'b0;
        dma_base_addr = 32'd0;
        dma_bit_len   = 32'd0;
        sha256_rdy    = 1'b0;
        fifo_wr_count = 9'd0;
        cmd_tready    = 1'b0;
        sts_tdata     = 8'd0;
        sts_tvalid    = 1'b0;
        tick(3);
        checkOutput("reset_tvalid", 72'(cmd_tvalid_o), 72'd0);
        checkOutput("reset_sts_tready", 72'(sts_tready_o), 72'd0);
        checkOutput("reset_busy", 72'(busy_o), 72'd0);
        checkOutput("reset_done", 72'(done_o), 72'd0);
        checkOutput("reset_err", 72'(err_o), 72'd0);
        checkOutput("reset_code", 72'(err_code_o), 72'd0);
        checkOutput("reset_state", 72'(dbg_state_o), 72'(S_IDLE));
        checkOutput("reset_tdata", cmd_tdata_o, 72'd0);
        rst = 1'b0;
        tick();
        checkOutput("sts_tready_after_reset", 72'(sts_tready_o), 72'd1);

        $display("[TB] single-block job");
        dma_enable = 1'b1;
        sha256_rdy = 1'b1;
        push_job(32'h1000_0000, 32'd512);
        applyStimulus(32'h1000_0000, 32'd512);
        checkOutput("t1_busy", 72'(busy_o), 72'd1);
        accept_cmd("t1_cmd", 0);
        send_sts(8'h80);
        wait_done("t1");

        $display("[TB] three-chunk job, unaligned base, outstanding limit");
        push_job(32'h2000_0004, 32'd1224);
        applyStimulus(32'h2000_0004, 32'd1224);
        accept_cmd("t2_cmd0", 0);
        accept_cmd("t2_cmd1", 10);
        expect_no_issue("t2_outst_limit", 10);
        checkOutput("t2_waiting_state", 72'(dbg_state_o), 72'(S_CHECK));
        send_sts(8'h80);
        accept_cmd("t2_cmd2", 0);
        send_sts(8'h81);
        send_sts(8'h82);
        wait_done("t2");

        $display("[TB] FIFO high-water throttle");
        fifo_wr_count = 9'h1E1;
        push_job(32'h3000_0000, 32'd512);
        applyStimulus(32'h3000_0000, 32'd512);
        expect_no_issue("t3_fifo_hold", 50);
        fifo_wr_count = 9'h1E0;
        tick();
        checkOutput("t3_fifo_release", 72'(cmd_tvalid_o), 72'd1);
        accept_cmd("t3_cmd", 0);
        send_sts(8'h80);
        wait_done("t3");

        $display("[TB] tag mismatch");
        push_job(32'h4000_0000, 32'd1024);
        applyStimulus(32'h4000_0000, 32'd1024);
        accept_cmd("t4_cmd0", 0);
        send_sts(8'h81);
        wait_err("t4", 3'd4);
        expect_no_issue("t4_no_cmds", 10);
        checkOutput("t4_error_held", 72'(dbg_state_o), 72'(S_ERROR));
        exp_q.delete();
        dma_enable = 1'b0;
        tick();
        checkOutput("t4_to_idle", 72'(dbg_state_o), 72'(S_IDLE));
        checkOutput("t4_err_sticky", 72'(err_o), 72'd1);
        dma_enable = 1'b1;

        $display("[TB] abort with two outstanding");
        push_job(32'h5000_0000, 32'd2048);
        applyStimulus(32'h5000_0000, 32'd2048);
        checkOutput("t5_err_cleared", 72'(err_o), 72'd0);
        accept_cmd("t5_cmd0", 0);
        accept_cmd("t5_cmd1", 0);
        dma_enable = 1'b0;
        tick();
        checkOutput("t5_drain", 72'(dbg_state_o), 72'(S_DRAIN));
        checkOutput("t5_drain_busy", 72'(busy_o), 72'd1);
        send_sts(8'h80);
        send_sts(8'h81);
        wait_err("t5", 3'd5);
        exp_q.delete();
        tick();
        checkOutput("t5_to_idle", 72'(dbg_state_o), 72'(S_IDLE));
        dma_enable = 1'b1;

        $display("[TB] start ignored when hasher busy or length zero");
        sha256_rdy = 1'b0;
        applyStimulus(32'h6000_0000, 32'd512);
        tick();
        checkOutput("t6_not_ready", 72'(dbg_state_o), 72'(S_IDLE));
        sha256_rdy = 1'b1;
        applyStimulus(32'h6000_0000, 32'd0);
        tick();
        checkOutput("t6_zero_len", 72'(busy_o), 72'd0);
        checkOutput("t6_err_kept", 72'(err_o), 72'd1);

        $display("[TB] bus error priority and first-error latch");
        push_job(32'h7000_0000, 32'd256);
        applyStimulus(32'h7000_0000, 32'd256);
        accept_cmd("t7_cmd", 0);
        send_sts(8'h40);
        wait_err("t7", 3'd1);
        send_sts(8'h20);
        checkOutput("t7_code_kept", 72'(err_code_o), 72'd1);
        dma_enable = 1'b0;
        tick();
        dma_enable = 1'b1;
        push_job(32'h8000_0000, 32'd256);
        applyStimulus(32'h8000_0000, 32'd256);
        accept_cmd("t8_cmd", 0);
        send_sts(8'h71);
        wait_err("t8", 3'd3);
        dma_enable = 1'b0;
        tick();
        dma_enable = 1'b1;

        $display("[TB] withheld status");
        push_job(32'h9000_0000, 32'd512);
        applyStimulus(32'h9000_0000, 32'd512);
        accept_cmd("t9_cmd", 0);
`ifdef DMA_SEQ_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            while (!err_o && waited < 300) begin
                tick();
                waited++;
            end
            checkOutput("t9_wd_cycles", 72'((waited >= 95) && (waited <= 105)), 72'd1);
            wait_err("t9", 3'd6);
            dma_enable = 1'b0;
            tick();
            dma_enable = 1'b1;
        end
`else
        tick(150);
        checkOutput("t9_no_watchdog", 72'(err_o), 72'd0);
        checkOutput("t9_still_busy", 72'(busy_o), 72'd1);
        send_sts(8'h80);
        wait_done("t9");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
